// File: rtl/apb_global_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_global_pkg
//  Purpose  : Shared types and constants for the APB completer memory:
//             FSM state encoding, transfer direction, response kind and the
//             APB pprot encodings, plus a small pprot decode helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package apb_global_pkg;

    // Largest value the 4-bit wait_states input can request.
    localparam int MAX_WAIT_STATES = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_slave_state_e;

    typedef enum logic {
        TX_READ  = 1'b0,
        TX_WRITE = 1'b1
    } tx_type_e;

    typedef enum logic {
        SLV_OKAY  = 1'b0,
        SLV_ERROR = 1'b1
    } slave_error_e;

    // pprot[0] = privileged, pprot[1] = nonsecure, pprot[2] = instruction
    typedef enum logic [2:0] {
        PROT_DATA_SEC_NORMAL    = 3'b000,
        PROT_DATA_SEC_PRIV      = 3'b001,
        PROT_DATA_NSEC_NORMAL   = 3'b010,
        PROT_DATA_NSEC_PRIV     = 3'b011,
        PROT_INSTR_SEC_NORMAL   = 3'b100,
        PROT_INSTR_SEC_PRIV     = 3'b101,
        PROT_INSTR_NSEC_NORMAL  = 3'b110,
        PROT_INSTR_NSEC_PRIV    = 3'b111
    } protection_type_e;

    function automatic logic prot_is_nonsecure(input logic [2:0] prot);
        return prot[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_mem_array.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_mem_array
//  Purpose  : Byte-strobed word storage, cleared by reset. Writes are
//             applied on the rising clock edge for every lane whose strobe
//             is set; reads are combinational from the word index.
//  Ports    : clk      - clock
//             rst      - asynchronous active-high reset (zeroes contents)
//             i_we     - write enable
//             i_idx    - word index
//             i_strb   - byte lane strobes
//             i_wdata  - write data
//             o_rdata  - read data of word i_idx
//  Revision : 1.0 - initial release
// ============================================================================
module apb_slave_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [DATA_WIDTH/8-1:0] i_strb,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int c_lanes = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] w_word [DEPTH];

    generate
        for (genvar gw = 0; gw < DEPTH; gw++) begin : g_word
            logic [DATA_WIDTH-1:0] r_word;
            logic                  w_sel;

            assign w_sel = i_we && (i_idx == IDX_W'(gw));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_word <= '0;
                end else if (w_sel) begin
                    for (int l = 0; l < c_lanes; l++) begin
                        if (i_strb[l]) begin
                            r_word[l*8 +: 8] <= i_wdata[l*8 +: 8];
                        end
                    end
                end
            end

            assign w_word[gw] = r_word;
        end
    endgenerate

    assign o_rdata = w_word[i_idx];

endmodule
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_mem
//  Purpose  : APB completer in front of a small byte-strobed memory with
//             programmable wait states, address/alignment error response
//             and a sticky protocol-violation monitor.
//  Config   : APB_PPROT_CHECK_EN - when defined, nonsecure (pprot[1]=1)
//             transfers to the upper half of the word range get pslverr.
//  Ports    : pclk, preset (async, active high)
//             psel, penable, pwrite, paddr, pwdata, pstrb, pprot - APB request
//             wait_states   - wait states for the next transfer
//             pready, prdata, pslverr - APB response (zero outside the
//                                       completing cycle)
//             protocol_err  - sticky protocol violation flag
//  Revision : 1.0 - initial release
// ============================================================================
module apb_slave_mem
    import apb_global_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          MEM_DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_1000
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDRESS_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0]    pwdata,
    input  logic [DATA_WIDTH/8-1:0]  pstrb,
    input  logic [2:0]               pprot,
    input  logic [3:0]               wait_states,
    output logic                     pready,
    output logic [DATA_WIDTH-1:0]    prdata,
    output logic                     pslverr,
    output logic                     protocol_err
);

    localparam int c_bytes   = DATA_WIDTH / 8;
    localparam int c_idx_w   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int c_align_w = $clog2(c_bytes);

    // One extra bit so the end-of-window compare cannot wrap.
    localparam logic [ADDRESS_WIDTH:0]   c_base_ext   = (ADDRESS_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDRESS_WIDTH:0]   c_limit_ext  = c_base_ext + (ADDRESS_WIDTH+1)'(MEM_DEPTH * c_bytes);
    localparam logic [ADDRESS_WIDTH-1:0] c_base       = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [ADDRESS_WIDTH-1:0] c_bytes_a    = ADDRESS_WIDTH'(c_bytes);
    localparam logic [ADDRESS_WIDTH-1:0] c_align_mask = ADDRESS_WIDTH'((1 << c_align_w) - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    apb_slave_state_e          r_state;
    logic [3:0]                r_cnt;
    logic                      r_pready;
    slave_error_e              r_err;
    tx_type_e                  r_tx;
    logic [ADDRESS_WIDTH-1:0]  r_addr;
    logic [c_idx_w-1:0]        r_idx;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_strb;
    logic [2:0]                r_prot;
    logic                      r_proto_err;

    // ------------------------------------------------------------------
    // Address decode on the live request (used while capturing in SETUP)
    // ------------------------------------------------------------------
    logic [ADDRESS_WIDTH:0]    w_addr_ext;
    logic [ADDRESS_WIDTH-1:0]  w_offset;
    logic [c_idx_w-1:0]        w_idx;
    logic                      w_out_of_range;
    logic                      w_misaligned;
    logic                      w_prot_err;
    logic                      w_setup_err;
    logic                      w_capture_mismatch;
    logic                      w_we;
    logic [DATA_WIDTH-1:0]     w_rdata;

    assign w_addr_ext     = {1'b0, paddr};
    assign w_out_of_range = (w_addr_ext < c_base_ext) || (w_addr_ext >= c_limit_ext);
    assign w_misaligned   = |(paddr & c_align_mask);
    assign w_offset       = paddr - c_base;
    // Index is only meaningful when the address is in range; otherwise the
    // transfer is flagged as an error and the index is never used.
    assign w_idx          = c_idx_w'(w_offset / c_bytes_a);

`ifdef APB_PPROT_CHECK_EN
    assign w_prot_err = prot_is_nonsecure(pprot) &&
                        (w_idx >= c_idx_w'(MEM_DEPTH / 2));
`else
    assign w_prot_err = 1'b0;
`endif

    assign w_setup_err = w_out_of_range || w_misaligned || w_prot_err;

    assign w_capture_mismatch = (r_addr  != paddr)  ||
                                ((r_tx == TX_WRITE) != pwrite) ||
                                (r_wdata != pwdata) ||
                                (r_strb  != pstrb)  ||
                                (r_prot  != pprot);

    // ------------------------------------------------------------------
    // FSM: r_pready is pre-computed so that it is high exactly while the
    // state is ACCESS with the wait counter at zero.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_pready    <= 1'b0;
            r_err       <= SLV_OKAY;
            r_tx        <= TX_READ;
            r_addr      <= '0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_strb      <= '0;
            r_prot      <= 3'b000;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pready <= 1'b0;
                    if (penable) begin
                        r_proto_err <= 1'b1;
                    end
                    if (psel && !penable) begin
                        r_state <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    r_addr   <= paddr;
                    r_idx    <= w_idx;
                    r_tx     <= pwrite ? TX_WRITE : TX_READ;
                    r_wdata  <= pwdata;
                    r_strb   <= pstrb;
                    r_prot   <= pprot;
                    r_err    <= w_setup_err ? SLV_ERROR : SLV_OKAY;
                    r_cnt    <= wait_states;
                    r_pready <= (wait_states == 4'd0);
                    if (!pwrite && (pstrb != '0)) begin
                        r_proto_err <= 1'b1;
                    end
                    r_state <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (psel && penable && w_capture_mismatch) begin
                        r_proto_err <= 1'b1;
                    end
                    if (r_pready) begin
                        // Completing cycle; a new setup phase may already
                        // be on the bus.
                        r_pready <= 1'b0;
                        r_state  <= (psel && !penable) ? ST_SETUP : ST_IDLE;
                    end else if (!psel) begin
                        // Abort before completion: nothing is written.
                        r_state <= ST_IDLE;
                    end else begin
                        if (!penable) begin
                            r_proto_err <= 1'b1;
                        end
                        r_cnt    <= r_cnt - 4'd1;
                        r_pready <= (r_cnt == 4'd1);
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_pready <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    assign w_we = r_pready && (r_tx == TX_WRITE) && (r_err == SLV_OKAY);

    apb_slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (c_idx_w)
    ) u_array (
        .clk     (pclk),
        .rst     (preset),
        .i_we    (w_we),
        .i_idx   (r_idx),
        .i_strb  (r_strb),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Response: everything gated by the completing cycle
    // ------------------------------------------------------------------
    assign pready       = r_pready;
    assign pslverr      = r_pready && (r_err == SLV_ERROR);
    assign prdata       = (r_pready && (r_tx == TX_READ) && (r_err == SLV_OKAY)) ? w_rdata : '0;
    assign protocol_err = r_proto_err;

endmodule
`default_nettype wire
